// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds the FetchCount/StallCount performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b0,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] InstrAddress,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [15:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegAddr,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
`endif
    output logic        AlignErr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pcplus4_q, ifid_pcplus4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        align_err_q, align_err_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        load_valid;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = ifid_pcplus4_q + {{14{BranchOffset[15]}}, BranchOffset, 2'b00};
    assign jump_target   = {ifid_pcplus4_q[31:28], JumpIndex, 2'b00};
    assign jr_target     = {JumpRegAddr[31:2], 2'b00};
    assign redirect      = JumpReg | Jump | BranchTaken;

    always_comb begin
        redirect_target = branch_target;
        if (JumpReg) begin
            redirect_target = jr_target;
        end else if (Jump) begin
            redirect_target = jump_target;
        end
    end

    always_comb begin
        pc_d           = pc_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pcplus4_d = ifid_pcplus4_q;
        ifid_valid_d   = ifid_valid_q;
        load_valid     = 1'b0;
        align_err_d    = JumpReg & (JumpRegAddr[1:0] != 2'b00);

        if (redirect) begin
            pc_d = redirect_target;
            // Redirect overrides Stall; the redirect-cycle fetch survives only as a delay slot.
            if (DELAY_SLOT && !Flush) begin
                load_valid = 1'b1;
            end else begin
                ifid_instr_d = NOP_WORD;
                ifid_valid_d = 1'b0;
            end
        end else if (Stall) begin
            if (Flush) begin
                ifid_instr_d = NOP_WORD;
                ifid_valid_d = 1'b0;
            end
        end else begin
            pc_d = pc_plus4;
            if (Flush) begin
                ifid_instr_d = NOP_WORD;
                ifid_valid_d = 1'b0;
            end else begin
                load_valid = 1'b1;
            end
        end

        if (load_valid) begin
            ifid_instr_d   = Instruction;
            ifid_pcplus4_d = pc_plus4;
            ifid_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q           <= RESET_PC;
            ifid_instr_q   <= NOP_WORD;
            ifid_pcplus4_q <= 32'h0000_0000;
            ifid_valid_q   <= 1'b0;
            align_err_q    <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pcplus4_q <= ifid_pcplus4_d;
            ifid_valid_q   <= ifid_valid_d;
            align_err_q    <= align_err_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_count_q <= 32'h0000_0000;
            stall_count_q <= 32'h0000_0000;
        end else begin
            if (load_valid) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (Stall && !redirect) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign FetchCount = fetch_count_q;
    assign StallCount = stall_count_q;
`endif

    assign InstrAddress     = pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PCPlus4     = ifid_pcplus4_q;
    assign IFID_Valid       = ifid_valid_q;
    assign AlignErr         = align_err_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS datapath: owns the program counter, drives the word address into the combinational instruction memory and captures the returned instruction into the IF/ID pipeline register.
- Computes sequential, branch, jump and jump-register next-PC values.
- Handles stall, flush and redirect from the decode stage.
- Sits directly upstream of the instruction memory and feeds the decode stage.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- DELAY_SLOT, 0, 1 = instruction fetched in the redirect cycle is kept (MIPS delay slot); 0 = it is squashed.
- NOP_WORD, 32'h00000000, bubble encoding written into IF/ID on flush, squash and reset.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- InstrAddress  output  32  current PC to instruction memory; combinational copy of the PC register
- Instruction  input  32  word returned by instruction memory for InstrAddress, same cycle
- Stall  input  1  hold PC and IF/ID (hazard unit)
- Flush  input  1  write bubble into IF/ID
- BranchTaken  input  1  conditional branch resolved taken in ID
- BranchOffset  input  16  branch immediate (word offset, signed)
- Jump  input  1  j/jal in ID
- JumpIndex  input  26  jump target field
- JumpReg  input  1  jr in ID
- JumpRegAddr  input  32  register target for jr
- IFID_Instruction  output  32  registered instruction to decode
- IFID_PCPlus4  output  32  registered PC+4 of that instruction
- IFID_Valid  output  1  IF/ID holds a real instruction
- AlignErr  output  1  one-cycle pulse on a misaligned jr target

Behaviour:
- Reset, asynchronous: PC = RESET_PC, IFID_Instruction = NOP_WORD, IFID_PCPlus4 = 0, IFID_Valid = 0, AlignErr = 0.
- InstrAddress = PC. Memory lookup is combinational, so the fetch latency from PC to IF/ID is 1 cycle.
- PCPlus4 = PC + 4, modulo 2^32. 32'hFFFFFFFC wraps to 0.
- Branch target = IFID_PCPlus4 + (sign-extend(BranchOffset) << 2), modulo 2^32.
- Jump target = {IFID_PCPlus4[31:28], JumpIndex, 2'b00}.
- JumpReg target = {JumpRegAddr[31:2], 2'b00}.
  - If JumpRegAddr[1:0] != 0 while JumpReg = 1, AlignErr = 1 on the next cycle only.
- Redirect = JumpReg | Jump | BranchTaken. Target priority: JumpReg > Jump > BranchTaken.
- Per rising edge, highest priority first:
  1. Redirect (overrides Stall): PC <= target.
     - DELAY_SLOT = 0: IF/ID <= bubble (NOP_WORD, Valid 0).
     - DELAY_SLOT = 1: IF/ID <= {Instruction, PCPlus4, Valid 1}.
     - Flush still forces a bubble in either mode.
  2. Stall, no redirect: PC and IF/ID hold. Flush + Stall: IF/ID <= bubble and PC holds.
  3. Otherwise: PC <= PCPlus4.
     - IF/ID <= {Instruction, PCPlus4, Valid 1}, or a bubble if Flush = 1.
- Bubble means IFID_Instruction = NOP_WORD, IFID_Valid = 0, IFID_PCPlus4 unchanged.
- Reset asserted mid-stall or mid-redirect wins immediately. The first fetch after deassertion is at RESET_PC.
- Redirect and control inputs are only sampled on clock edges. X on inactive controls is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs FetchCount[31:0] and StallCount[31:0], both reset to 0.
  - FetchCount increments on each edge where IF/ID loads with Valid 1.
  - StallCount increments on each edge with Stall = 1 and no redirect.
  - Both counters wrap at 2^32.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then 4 free-running cycles with memory[i] = i*4 -> InstrAddress 0,4,8,12; IFID_Instruction 0,4,8 with IFID_PCPlus4 4,8,12; IFID_Valid rises 1 cycle after reset release.
- At PC = 8, assert Stall for 2 cycles -> InstrAddress stays 8, IF/ID frozen at {4,8}; fetch resumes with 8 -> {8,12}; StallCount = 2 when FETCH_PERF_CNT_EN is defined.
- IFID_PCPlus4 = 32'h00000020, BranchTaken with BranchOffset 16'hFFFE -> next PC 32'h00000018. DELAY_SLOT = 0: IFID_Valid = 0 for 1 cycle. DELAY_SLOT = 1: IFID_Valid stays 1.
- Simultaneous JumpReg (JumpRegAddr 32'h00000041), Jump and BranchTaken, plus Stall -> PC 32'h00000040, AlignErr pulses 1 cycle.
- Jump with IFID_PCPlus4 = 32'hA0000004, JumpIndex 26'h0000010 -> PC 32'hA0000040. Separately, PC = 32'hFFFFFFFC sequential -> PC 0.
- Flush asserted with Stall at PC = 12 -> IF/ID bubble, PC holds 12. Reset pulsed mid-redirect -> PC = RESET_PC immediately, outputs at reset values.
